fetch_queue: RTL
================

# fetch_queue

Instruction prefetch queue directly upstream of the x86 decoder. It fetches aligned 32-bit little-endian words from instruction memory, starting at a programmed start address. The bytes go into a 16-byte circular queue. The queue presents an 8-byte window with its byte count and address to the decoder, and the decoder retires bytes by returning a consume count each cycle.

## Interface
Parameters:
- QUEUE_BYTES, 16, queue capacity in bytes; must be a power of two, at least 8.
- WINDOW_BYTES, 8, bytes presented to the decoder.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  one-cycle pulse; flushes the queue and begins fetch at i_start_addr.
- i_start_addr  in  32  byte address of the first instruction.
- o_mem_req  out  1  read request; held with a stable address until acked.
- o_mem_addr  out  32  word-aligned read address.
- i_mem_ack  in  1  read data valid; only meaningful while o_mem_req=1.
- i_mem_data  in  32  read word; byte 0 is [7:0].
- o_win_bytes  out  64  window; byte k = queue[head+k]; bytes at or above o_win_count are zero.
- o_win_count  out  4  valid window bytes, 0..8 (min of occupancy and 8).
- o_win_addr  out  32  address of window byte 0.
- i_consume  in  4  bytes retired by the decoder this cycle, 0..8.
- o_busy  out  1  1 in RUN state.
- o_err  out  1  sticky; set when i_consume > o_win_count.

## Operation
- The FSM has two states.
  - IDLE: no requests; o_win_count=0.
  - RUN: fetching and presenting the window.
- i_start (any state):
  - Queue emptied (head=tail=count=0).
  - fetch_addr = i_start_addr & ~3.
  - o_win_addr = i_start_addr (see Configuration).
  - o_err cleared; state goes to RUN.
  - An i_mem_ack in the same cycle as i_start is discarded, and o_mem_req is 0 in the following cycle.
- Request rule (RUN): assert o_mem_req when no request is outstanding and free space (QUEUE_BYTES − count) ≥ 4. Only one request is outstanding at a time.
- On ack:
  - Append 4 bytes at tail; tail += 4 mod QUEUE_BYTES.
  - fetch_addr += 4, wrapping modulo 2^32.
  - o_mem_req drops the next cycle.
- On consume:
  - c = min(i_consume, o_win_count); head += c; o_win_addr += c, wrapping modulo 2^32.
  - If i_consume > o_win_count: o_err is set and only o_win_count bytes are removed.
- Simultaneous ack and consume: count_next = count − c + appended. The consume applies to bytes present before the edge, so count never exceeds QUEUE_BYTES.
- i_consume is ignored in IDLE.

## Timing
- Reset values:
  - o_mem_req=0, o_mem_addr=0.
  - o_win_bytes=0, o_win_count=0, o_win_addr=0.
  - o_busy=0, o_err=0; state IDLE.
- All outputs are registered.
- Fetch sequence, with i_start at edge 0:
  - o_mem_req=1 with o_mem_addr valid after edge 1.
  - An ack sampled at edge k gives o_win_count=4 after edge k (visible in cycle k+1).
- Peak throughput: one word per 2 cycles.
- The window reflects consume and append from the previous edge; the decoder must compute i_consume combinationally from the current window.
- Reset asserted mid-request aborts the request immediately. Any ack arriving after reset is ignored because o_mem_req=0.

## Configuration
- FETCH_QUEUE_UNALIGNED_EN defined:
  - Start address low bits s = i_start_addr[1:0] are honoured.
  - The first acked word appends only bytes s..3 (4−s bytes).
  - o_win_addr = i_start_addr.
- Not defined:
  - i_start_addr[1:0] is ignored.
  - o_win_addr = i_start_addr & ~3, and every append is 4 bytes.

## Test plan
- Basic fetch:
  - Stimulus: start at 0x1000; memory returns 0x04030201 then 0x08070605.
  - Required: o_mem_addr 0x1000 then 0x1004; window bytes 01..08, count 8, addr 0x1000.
- Consume with simultaneous ack:
  - Stimulus: queue holds 8 bytes; i_consume=3 and an ack land on the same edge.
  - Required: count 9, o_win_addr +3, first window byte = old byte 3.
- Full queue:
  - Stimulus: no consume; memory acks immediately.
  - Required: exactly 4 requests (count=16), then o_mem_req stays 0. Consuming 4 bytes re-enables a request at tail wrap (tail=0).
- Over-consume:
  - Stimulus: count=2, i_consume=5.
  - Required: count 0, o_win_addr +2, o_err=1 until the next i_start.
- Restart mid-request:
  - Stimulus: request to 0x2004 pending; i_start with 0x3000 and i_mem_ack in the same cycle.
  - Required: ack data discarded, count 0, next request to 0x3000.
- Unaligned start (with FETCH_QUEUE_UNALIGNED_EN):
  - Stimulus: start at 0x1002; word 0xDDCCBBAA.
  - Required: count 2, window bytes CC DD, o_win_addr 0x1002.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue feeding the x86 decoder.
// Fetches aligned 32-bit little-endian words into a circular byte queue and
// presents a registered window of up to WINDOW_BYTES bytes with its address.
// Optional feature macro: FETCH_QUEUE_UNALIGNED_EN -- honour the low two bits
// of the start address (the first word contributes only bytes s..3).
module fetch_queue #(
  parameter int QUEUE_BYTES  = 16,
  parameter int WINDOW_BYTES = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [31:0]               i_start_addr,
  output logic                      o_mem_req,
  output logic [31:0]               o_mem_addr,
  input  logic                      i_mem_ack,
  input  logic [31:0]               i_mem_data,
  output logic [8*WINDOW_BYTES-1:0] o_win_bytes,
  output logic [3:0]                o_win_count,
  output logic [31:0]               o_win_addr,
  input  logic [3:0]                i_consume,
  output logic                      o_busy,
  output logic                      o_err
);

`ifdef FETCH_QUEUE_UNALIGNED_EN
  localparam bit UNALIGNED_EN = 1'b1;
`else
  localparam bit UNALIGNED_EN = 1'b0;
`endif

  localparam int PTR_W = $clog2(QUEUE_BYTES);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state;
  logic [7:0]           q      [QUEUE_BYTES];
  logic [7:0]           q_next [QUEUE_BYTES];
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count;
  logic [1:0]           skip;     // leading bytes of the next word to drop

  logic                      run, ack_ok, over;
  logic [3:0]                take;
  logic [2:0]                n_app;
  logic [PTR_W-1:0]          head_nx, tail_nx;
  logic [CNT_W-1:0]          count_nx;
  logic [3:0]                win_cnt_nx;
  logic [8*WINDOW_BYTES-1:0] win_bytes_nx;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[8*sel +: 8];
  endfunction

  // Next queue contents, pointers and window as they will be after this edge.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    run    = (state == S_RUN);
    ack_ok = run && o_mem_req && i_mem_ack && !i_start;
    over   = run && (i_consume > o_win_count);
    take   = !run ? 4'd0 : (over ? o_win_count : i_consume);
    n_app  = ack_ok ? 3'(3'd4 - {1'b0, skip}) : 3'd0;

    q_next = q;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < n_app)
        q_next[tail + PTR_W'(j)] = word_byte(i_mem_data, skip + 2'(j));
    end

    head_nx  = head + PTR_W'(take);
    tail_nx  = tail + PTR_W'(n_app);
    count_nx = count - CNT_W'(take) + CNT_W'(n_app);

    win_cnt_nx = (count_nx > CNT_W'(WINDOW_BYTES)) ? 4'(WINDOW_BYTES) : 4'(count_nx);

    win_bytes_nx = '0;
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      if (4'(k) < win_cnt_nx)
        win_bytes_nx[8*k +: 8] = q_next[head_nx + PTR_W'(k)];
    end
  end

  // Queue storage: written only by appends, bytes beyond count are masked out.
  // NOTE: the byte array has no reset; stale bytes are never visible because the window masks by count.
  always_ff @(posedge i_clk) begin
    q <= q_next;
  end

  // Control FSM with registered request, window and status outputs.
  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_win_bytes <= '0;
      o_win_count <= '0;
      o_win_addr  <= '0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      skip        <= '0;
    end else if (i_start) begin
      // Flush and restart; any ack in this cycle belongs to the old stream.
      state       <= S_RUN;
      o_busy      <= 1'b1;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= {i_start_addr[31:2], 2'b00};
      o_win_bytes <= '0;
      o_win_count <= '0;
      o_win_addr  <= UNALIGNED_EN ? i_start_addr : {i_start_addr[31:2], 2'b00};
      o_err       <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      skip        <= UNALIGNED_EN ? i_start_addr[1:0] : 2'b00;
    end else if (run) begin
      head        <= head_nx;
      tail        <= tail_nx;
      count       <= count_nx;
      o_win_bytes <= win_bytes_nx;
      o_win_count <= win_cnt_nx;
      o_win_addr  <= o_win_addr + 32'(take);
      if (over)
        o_err <= 1'b1;
      if (ack_ok) begin
        o_mem_req  <= 1'b0;
        o_mem_addr <= o_mem_addr + 32'd4;
        skip       <= 2'b00;
      end else if (!o_mem_req &&
                   ((CNT_W'(QUEUE_BYTES) - count_nx) >= CNT_W'(4))) begin
        o_mem_req <= 1'b1;
      end
    end
  end

endmodule
